// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: ALU results win each cycle, and load results wait in a small FIFO.
// Also provides a combinational bypass lookup of the youngest pending write for two read addresses.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_rd,
  input  logic [31:0]              ld_data,
  output logic                     alu_stall,
  output logic [$clog2(DEPTH):0]   ld_count,
  output logic                     RegWrite,
  output logic [4:0]               A3,
  output logic [31:0]              WD3,
  input  logic [4:0]               fwd_a1,
  input  logic [4:0]               fwd_a2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [31:0]              fwd_data1,
  output logic [31:0]              fwd_data2
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [SW-1:0] LIM_M1   = SW'(STARVE_LIMIT - 1);

  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             stall_q, stall_d;
  logic             we_q, we_d;
  logic [4:0]       a3_q, a3_d;
  logic [31:0]      wd3_q, wd3_d;

  logic alu_wr, empty, full, push, pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);
  assign ld_ready = rst & ~full;
  assign alu_wr   = alu_valid & (alu_rd != 5'd0);
  // A load racing an ALU write to the same rd is older and would be killed at once, so it is dropped here.
  assign push     = ld_valid & ld_ready & (ld_rd != 5'd0) & ~(alu_wr & (ld_rd == alu_rd));
  assign pop      = ~alu_wr & ~empty;

  always_comb begin
    rd_d     = rd_q;
    data_d   = data_q;
    live_d   = live_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    we_d     = 1'b0;
    a3_d     = a3_q;
    wd3_d    = wd3_q;

    if (alu_wr) begin
      for (int j = 0; j < DEPTH; j++)
        if (rd_q[j] == alu_rd) live_d[j] = 1'b0;
      we_d  = 1'b1;
      a3_d  = alu_rd;
      wd3_d = alu_data;
    end else if (pop && live_q[rd_ptr_q]) begin
      we_d  = 1'b1;
      a3_d  = rd_q[rd_ptr_q];
      wd3_d = data_q[rd_ptr_q];
    end

    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + 1'b1;
    end
    if (push) begin
      rd_d[wr_ptr_q]   = ld_rd;
      data_d[wr_ptr_q] = ld_data;
      live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end

    cnt_d = cnt_q + CW'(push) - CW'(pop);

    // Saturating wait counter; only its comparison against the limit matters.
    if (empty || pop)         starve_d = '0;
    else if (starve_q < LIM_M1) starve_d = starve_q + 1'b1;
    else                      starve_d = starve_q;
    stall_d = (starve_q >= LIM_M1) & ~empty;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      a3_q     <= 5'd0;
      wd3_q    <= 32'd0;
    end else begin
      live_q   <= live_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      we_q     <= we_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  assign alu_stall = stall_q;
  assign ld_count  = cnt_q;
  assign RegWrite  = we_q;
  assign A3        = a3_q;
  assign WD3       = wd3_q;

  // Lowest priority is applied first so that younger sources overwrite older matches.
  function automatic logic [32:0] lookup(input logic [4:0] a);
    logic          hit;
    logic [31:0]   d;
    logic [AW-1:0] idx;
    hit = 1'b0;
    d   = 32'd0;
    if (a != 5'd0) begin
      if (we_q && (a3_q == a)) begin
        hit = 1'b1;
        d   = wd3_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + AW'(i);
        if ((CW'(i) < cnt_q) && live_q[idx] && (rd_q[idx] == a)) begin
          hit = 1'b1;
          d   = data_q[idx];
        end
      end
      if (alu_valid && (alu_rd == a)) begin
        hit = 1'b1;
        d   = alu_data;
      end
    end
    return {hit, d};
  endfunction

  assign {fwd_hit1, fwd_data1} = lookup(fwd_a1);
  assign {fwd_hit2, fwd_data2} = lookup(fwd_a2);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based reference model predicts each
// registered output, and a separate monitor compares those predictions one cycle later.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int LIM   = 8;

  logic        clk = 1'b0;
  logic        rst, alu_valid, ld_valid, ld_ready, alu_stall, RegWrite;
  logic [4:0]  alu_rd, ld_rd, A3, fwd_a1, fwd_a2;
  logic [31:0] alu_data, ld_data, WD3, fwd_data1, fwd_data2;
  logic        fwd_hit1, fwd_hit2;
  logic [$clog2(DEPTH):0] ld_count;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .alu_stall(alu_stall), .ld_count(ld_count),
    .RegWrite(RegWrite), .A3(A3), .WD3(WD3),
    .fwd_a1(fwd_a1), .fwd_a2(fwd_a2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  typedef struct {logic we; logic chka; logic [4:0] rd; logic [31:0] d; logic stall;} exp_t;
  typedef struct {logic [4:0] rd; logic [31:0] d; logic live;} ent_t;

  exp_t        expq[$];
  ent_t        mq[$];
  int          starve = 0;
  logic        lw_we = 1'b0;
  logic [4:0]  lw_rd = 5'd0;
  logic [31:0] lw_d  = 32'd0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
  endtask

  // Youngest-first bypass: ALU input, then live queued loads newest to oldest, then last write.
  task automatic mfwd(input logic [4:0] a, input logic av, input logic [4:0] ard,
                      input logic [31:0] adat, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = 32'd0;
    if (a != 5'd0) begin
      if (av && ard == a) begin
        h = 1'b1; d = adat;
      end else begin
        for (int i = mq.size() - 1; i >= 0; i--)
          if (!h && mq[i].live && mq[i].rd == a) begin
            h = 1'b1; d = mq[i].d;
          end
        if (!h && lw_we && lw_rd == a) begin
          h = 1'b1; d = lw_d;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] adat,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                     input logic [4:0] f1, input logic [4:0] f2);
    exp_t        e;
    logic        h, aw, pop, rdy;
    logic [31:0] d;
    @(negedge clk);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat; fwd_a1 = f1; fwd_a2 = f2;
    #1;
    e = '{we: 1'b0, chka: 1'b0, rd: 5'd0, d: 32'd0, stall: 1'b0};
    if (!r) begin
      chk("ld_ready_in_reset", 32'(ld_ready), 32'd0);
      mq.delete();
      starve = 0;
      lw_we = 1'b0;
      e.chka = 1'b1;
    end else begin
      rdy = (mq.size() != DEPTH);
      chk("ld_ready", 32'(ld_ready), 32'(rdy));
      chk("ld_count", 32'(ld_count), 32'(mq.size()));
      mfwd(f1, av, ard, adat, h, d);
      chk("fwd_hit1", 32'(fwd_hit1), 32'(h));
      chk("fwd_data1", fwd_data1, d);
      mfwd(f2, av, ard, adat, h, d);
      chk("fwd_hit2", 32'(fwd_hit2), 32'(h));
      chk("fwd_data2", fwd_data2, d);

      aw  = av && ard != 5'd0;
      pop = !aw && mq.size() > 0;
      e.stall = (starve >= LIM - 1) && mq.size() > 0;
      starve  = (mq.size() == 0 || pop) ? 0 : starve + 1;
      if (aw) begin
        e.we = 1'b1; e.chka = 1'b1; e.rd = ard; e.d = adat;
        foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
      end else if (pop && mq[0].live) begin
        e.we = 1'b1; e.chka = 1'b1; e.rd = mq[0].rd; e.d = mq[0].d;
      end
      if (pop) void'(mq.pop_front());
      if (lv && rdy && lrd != 5'd0 && !(aw && lrd == ard))
        mq.push_back('{rd: lrd, d: ldat, live: 1'b1});
      lw_we = e.we;
      if (e.we) begin
        lw_rd = e.rd; lw_d = e.d;
      end
    end
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  // Monitor: each registered output is compared against the prediction made one cycle earlier.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("RegWrite", 32'(RegWrite), 32'(e.we));
        chk("alu_stall", 32'(alu_stall), 32'(e.stall));
        if (e.chka) begin
          chk("A3", 32'(A3), 32'(e.rd));
          chk("WD3", WD3, e.d);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0; fwd_a1 = 5'd0; fwd_a2 = 5'd0;

    // Reset held with a load offered.
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 5'd0, 5'd0);
    idle(1);
    chk("ld_ready_after_reset", 32'(ld_ready), 32'd1);
    chk("ld_count_after_reset", 32'(ld_count), 32'd0);

    // ALU and load in the same cycle.
    cyc(1'b1, 1'b1, 5'd5, 32'hA, 1'b1, 5'd6, 32'hB, 5'd5, 5'd6);
    idle(3);

    // Fill the FIFO behind a busy ALU until the stall request appears.
    cyc(1'b1, 1'b1, 5'd1, $urandom, 1'b1, 5'd2, $urandom, 5'd2, 5'd1);
    cyc(1'b1, 1'b1, 5'd1, $urandom, 1'b1, 5'd3, $urandom, 5'd3, 5'd2);
    cyc(1'b1, 1'b1, 5'd1, $urandom, 1'b1, 5'd4, $urandom, 5'd4, 5'd3);
    cyc(1'b1, 1'b1, 5'd1, $urandom, 1'b1, 5'd6, $urandom, 5'd6, 5'd4);
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 5'd1, $urandom, 1'b1, 5'd8, $urandom, 5'd2, 5'd6);
    chk("stall_when_starved", 32'(alu_stall), 32'd1);
    chk("full_count", 32'(ld_count), 32'd4);
    idle(6);

    // Queued load killed by a younger ALU write to the same register.
    cyc(1'b1, 1'b1, 5'd1, 32'h5, 1'b1, 5'd7, 32'h11, 5'd7, 5'd0);
    cyc(1'b1, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    chk("waw_fwd_data1", fwd_data1, 32'h22);
    idle(3);

    // x0 writes from both sources.
    cyc(1'b1, 1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 32'h88, 5'd0, 5'd0);
    chk("x0_fwd_hit1", 32'(fwd_hit1), 32'd0);
    chk("x0_fwd_data1", fwd_data1, 32'd0);
    idle(2);

    // Current ALU input outranks a queued load for bypass.
    cyc(1'b1, 1'b1, 5'd1, 32'h9, 1'b1, 5'd3, 32'h1, 5'd0, 5'd0);
    cyc(1'b1, 1'b1, 5'd3, 32'h2, 1'b0, 5'd0, 32'd0, 5'd0, 5'd3);
    chk("bypass_hit2", 32'(fwd_hit2), 32'd1);
    chk("bypass_data2", fwd_data2, 32'h2);
    idle(3);

    // Randomized traffic with occasional mid-operation resets.
    for (int k = 0; k < 3000; k++)
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
          ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    idle(8);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
